mips_cpu_muldiv: RTL and testbench

//   Iterative multiply/divide unit beside the ALU in the execute stage, holding the

---
 rtl/mips_cpu_muldiv.sv | 185 ++++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up in a final cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here
// MUL   | one multiplier bit per cycle
// DIV   | one quotient bit per cycle
// FIX   | apply signs / divide-by-zero result, write hi/lo, pulse done
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] FC_MULT  = 6'b011000;
  localparam logic [5:0] FC_MULTU = 6'b011001;
  localparam logic [5:0] FC_DIV   = 6'b011010;
  localparam logic [5:0] FC_DIVU  = 6'b011011;
  localparam logic [5:0] FC_MTHI  = 6'b010001;
  localparam logic [5:0] FC_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] wq_q, wq_d;       // multiplier->product low half / dividend->quotient
  logic [WIDTH-1:0] mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             is_div_q, is_div_d;
  logic             negq_q, negq_d;
  logic             nega_q, nega_d;
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               signed_op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wq_d      = wq_q;
    mcand_d   = mcand_q;
    araw_d    = araw_q;
    is_div_d  = is_div_q;
    negq_d    = negq_q;
    nega_d    = nega_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    signed_op = ~FuncCode[0];
    sum       = {1'b0, acc_q} + (wq_q[0] ? {1'b0, mcand_q} : '0);
    shifted   = {acc_q, wq_q[WIDTH-1]};
    prod      = {acc_q, wq_q};
    quo       = wq_q;
    rem       = acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (FuncCode)
            FC_MULT, FC_MULTU, FC_DIV, FC_DIVU: begin
              state_d  = FuncCode[1] ? S_DIV : S_MUL;
              is_div_d = FuncCode[1];
              cnt_d    = CW'(WIDTH - 1);
              acc_d    = '0;
              wq_d     = signed_op ? abs_a : a;
              mcand_d  = signed_op ? abs_b : b;
              araw_d   = a;
              bzero_d  = (b == '0);
              negq_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              nega_d   = signed_op & a[WIDTH-1];
            end
            FC_MTHI: hi_d = a;
            FC_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        // multiplier sits in wq and shifts out as product bits shift in
        acc_d = sum[WIDTH:1];
        wq_d  = {sum[0], wq_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DIV: begin
        if (shifted >= {1'b0, mcand_q}) begin
          acc_d = shifted[WIDTH-1:0] - mcand_q;
          wq_d  = {wq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          wq_d  = {wq_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (negq_q) quo = ~wq_q + 1'b1;
          if (nega_q) rem = ~acc_q + 1'b1;
          if (bzero_q) begin
            lo_d = '1;
            hi_d = araw_q;
          end else begin
            lo_d = quo;
            hi_d = rem;
          end
        end else begin
          if (negq_q) prod = ~{acc_q, wq_q} + 1'b1;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      wq_q     <= '0;
      mcand_q  <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      negq_q   <= 1'b0;
      nega_q   <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wq_q     <= wq_d;
      mcand_q  <= mcand_d;
      araw_q   <= araw_d;
      is_div_q <= is_div_d;
      negq_q   <= negq_d;
      nega_q   <= nega_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed boundary cases plus random ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_mips_cpu_muldiv;

  localparam logic [5:0] FC_MULT  = 6'b011000;
  localparam logic [5:0] FC_MULTU = 6'b011001;
  localparam logic [5:0] FC_DIV   = 6'b011010;
  localparam logic [5:0] FC_DIVU  = 6'b011011;
  localparam logic [5:0] FC_MTHI  = 6'b010001;
  localparam logic [5:0] FC_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  FuncCode;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi, m_lo;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .FuncCode(FuncCode),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [5:0] fc, input logic [31:0] av,
                                             input logic [31:0] bv);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = 64'(signed'(av));
    sb = 64'(signed'(bv));
    ua = {32'b0, av};
    ub = {32'b0, bv};
    ref_result = '0;
    case (fc)
      FC_MULT:  ref_result = sa * sb;
      FC_MULTU: ref_result = ua * ub;
      FC_DIV: begin
        if (bv == 0) ref_result = {av, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_result = {r[31:0], q[31:0]};
        end
      end
      FC_DIVU: begin
        if (bv == 0) ref_result = {av, 32'hFFFF_FFFF};
        else ref_result = {av % bv, av / bv};
      end
      default: ref_result = {m_hi, m_lo};
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: pick_val = 32'h0;
      1: pick_val = 32'h8000_0000;
      2: pick_val = 32'hFFFF_FFFF;
      3: pick_val = $urandom_range(0, 20);
      4: pick_val = -$urandom_range(1, 20);
      default: pick_val = $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [5:0] fc, input logic [31:0] av, input logic [31:0] bv,
                        input bit poke);
    logic [63:0] exp;
    logic [31:0] old_hi, old_lo;
    bit hold_ok;
    int n;
    @(negedge clk);
    start = 1'b1; FuncCode = fc; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; FuncCode = 6'($urandom); a = $urandom; b = $urandom;
    if (fc == FC_MULT || fc == FC_MULTU || fc == FC_DIV || fc == FC_DIVU) begin
      exp = ref_result(fc, av, bv);
      old_hi = m_hi; old_lo = m_lo;
      hold_ok = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        if (hi !== old_hi || lo !== old_lo || done !== 1'b0) hold_ok = 1'b0;
        start = poke && (n == 5);
        if (start) begin FuncCode = FC_MTHI; a = $urandom; end
        n++;
        @(negedge clk);
      end
      start = 1'b0;
      check_val("busy_cycles", 64'(n), 64'd33);
      check_val("hold_old", 64'(hold_ok), 64'd1);
      check_val("done_pulse", 64'(done), 64'd1);
      check_val("hi", 64'(hi), 64'(exp[63:32]));
      check_val("lo", 64'(lo), 64'(exp[31:0]));
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      @(negedge clk);
      check_val("done_clear", 64'(done), 64'd0);
    end else begin
      if (fc == FC_MTHI) m_hi = av;
      if (fc == FC_MTLO) m_lo = av;
      check_val("idle_busy", 64'(busy), 64'd0);
      check_val("idle_done", 64'(done), 64'd0);
      check_val("idle_hi", 64'(hi), 64'(m_hi));
      check_val("idle_lo", 64'(lo), 64'(m_lo));
    end
  endtask

  initial begin
    logic [5:0] codes [8];
    int n;
    codes = '{FC_MULT, FC_MULTU, FC_DIV, FC_DIVU, FC_MTHI, FC_MTLO, 6'b100000, 6'b011100};
    reset = 1'b1; start = 1'b0; FuncCode = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    run_op(FC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(FC_MULT,  32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(FC_DIVU,  32'd100, 32'd7, 1'b0);
    run_op(FC_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(FC_DIV,   32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(FC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(FC_DIVU,  32'd5, 32'd0, 1'b0);
    run_op(FC_DIV,   32'hFFFF_FFF0, 32'd0, 1'b0);
    run_op(FC_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(FC_MTLO,  32'h1234, 32'd0, 1'b0);
    run_op(FC_MTHI,  32'hCAFE_0001, 32'd0, 1'b0);
    run_op(6'b100000, 32'h5555, 32'h1, 1'b0);
    run_op(FC_MULT,  32'd1000, 32'hFFFF_FF00, 1'b1);

    for (int i = 0; i < 40; i++)
      run_op(codes[$urandom_range(0, 7)], pick_val(), pick_val(), bit'($urandom_range(0, 1)));

    // reset in the middle of a multiply discards it
    run_op(FC_MTHI, 32'h1111_2222, 32'd0, 1'b0);
    run_op(FC_MTLO, 32'h3333_4444, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; FuncCode = FC_MULT; a = 32'd12345; b = 32'd678;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (busy === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("rstmid_busy", 64'(busy), 64'd0);
    check_val("rstmid_done", 64'(done), 64'd0);
    check_val("rstmid_hi", 64'(hi), 64'd0);
    check_val("rstmid_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check_val("rstmid_nodone", 64'(done), 64'd0);
    run_op(FC_DIVU, 32'd9, 32'd3, 1'b0);

    // reset wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; FuncCode = FC_MTLO; a = 32'h77;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    m_hi = '0; m_lo = '0;
    check_val("rst_start_lo", 64'(lo), 64'd0);
    check_val("rst_start_hi", 64'(hi), 64'd0);
    check_val("rst_start_busy", 64'(busy), 64'd0);
    run_op(FC_MULTU, 32'd6, 32'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
